module_mc_controller: RTL

Multicycle control unit for the RV32I subset core (lw, sw, R-type, I-type ALU, beq/bne, jal). A Moore FSM sequences the shared datapath (one memory, one ALU, instruction register) over 3–5 cycles per instruction. It drives the memory address mux, instruction-register load, PC write, ALU operand muxes, ALU operation, result mux and register-file write. It sits between the instruction register and the datapath muxes in the multicycle variant of the processor.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/module_mc_alu_dec.sv | 22 ++
 rtl/module_mc_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Build option MC_MEM_READY_EN (used in module_mc_controller) adds memory wait states.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/module_mc_alu_dec.sv
// ALU operation decode from funct3/funct7 for register and immediate ALU instructions.
module module_mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/module_mc_controller.sv
// Moore control FSM for the multicycle RV32I core (lw, sw, R/I ALU, beq/bne, jal).
// Define MC_MEM_READY_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready_i.
//
//   state      | meaning
//   FETCH      | read instruction at PC, latch IR/old PC, PC <= PC+4
//   DECODE     | read registers, ALUOut <= old PC + imm (branch target)
//   MEMADR     | ALUOut <= rs1 + imm
//   MEMREAD    | read data memory at ALUOut
//   MEMWB      | rd <= loaded data
//   MEMWRITE   | write rs2 to data memory at ALUOut
//   EXECR      | ALUOut <= rs1 op rs2
//   EXECI      | ALUOut <= rs1 op imm
//   ALUWB      | rd <= ALUOut
//   BRANCH     | compare rs1/rs2, PC <= ALUOut if taken
//   JAL        | PC <= target, ALUOut <= old PC + 4
module module_mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] imm_src_o,
    output logic [2:0] alu_control_o,
    output logic       reg_write_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    state_t     state;
    state_t     state_next;
    logic       ready;
    logic [2:0] alu_dec_ctrl;
    logic       pc_w, mem_w, ir_w, reg_w, done, illegal;

`ifdef MC_MEM_READY_EN
    assign ready = mem_ready_i;
`else
    assign ready = mem_ready_i | 1'b1;
`endif

    module_mc_alu_dec u_alu_dec (
        .op5         (op_i[5]),
        .funct3      (funct3_i),
        .funct7b5    (funct7b5_i),
        .alu_control (alu_dec_ctrl)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_FETCH;
        else          state <= state_next;
    end

    always_comb begin
        pc_w          = 1'b0;
        mem_w         = 1'b0;
        ir_w          = 1'b0;
        reg_w         = 1'b0;
        done          = 1'b0;
        illegal       = 1'b0;
        adr_src_o     = ADR_PC;
        result_src_o  = RES_ALUOUT;
        alu_src_a_o   = SRCA_PC;
        alu_src_b_o   = SRCB_RS2;
        alu_control_o = ALU_ADD;
        case (state)
            S_FETCH: begin
                // a stalled fetch must not advance PC or overwrite IR
                pc_w         = ready;
                ir_w         = ready;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                illegal     = !is_supported(op_i);
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMREAD: adr_src_o = ADR_ALUOUT;
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_w        = 1'b1;
                done         = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o = ADR_ALUOUT;
                mem_w     = 1'b1;
                done      = ready;
            end
            S_EXECR: begin
                alu_src_a_o   = SRCA_RS1;
                alu_control_o = alu_dec_ctrl;
            end
            S_EXECI: begin
                alu_src_a_o   = SRCA_RS1;
                alu_src_b_o   = SRCB_IMM;
                alu_control_o = alu_dec_ctrl;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
                done  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o   = SRCA_RS1;
                alu_control_o = ALU_SUB;
                pc_w          = zero_i ^ funct3_i[0];
                done          = 1'b1;
            end
            S_JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_w        = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_src_o = imm_sel(op_i);

    // reset masks the strobes so nothing commits while rst_n_i is low
    assign pc_write_o   = pc_w    & rst_n_i;
    assign mem_write_o  = mem_w   & rst_n_i;
    assign ir_write_o   = ir_w    & rst_n_i;
    assign reg_write_o  = reg_w   & rst_n_i;
    assign instr_done_o = done    & rst_n_i;
    assign illegal_o    = illegal & rst_n_i;

endmodule
